// File: rtl/vga_sprite_line_compositor.sv
// Double-buffered scanline compositor: map line plus NUM_SPR 1-bit sprite rows,
// streamed through a writable palette to registered 8-bit R/G/B.
module vga_sprite_line_compositor #(
  parameter int unsigned H_ACTIVE = 848,
  parameter int unsigned BPP      = 2,
  parameter int unsigned NUM_SPR  = 2,
  parameter int unsigned SPR_W    = 57,
  parameter int unsigned SPR_H    = 57,
  parameter int unsigned COORD_W  = 11,
  localparam int unsigned SEL_W   = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
  localparam int unsigned ROW_W   = (SPR_H > 1) ? $clog2(SPR_H) : 1
) (
  input  logic                       pixelCLK,
  input  logic                       RST,
  input  logic                       line_start,
  input  logic [COORD_W-1:0]         line_y,
  input  logic [H_ACTIVE*BPP-1:0]    map_line,
  input  logic [NUM_SPR-1:0]         spr_en,
  input  logic [NUM_SPR*COORD_W-1:0] spr_x,
  input  logic [NUM_SPR*COORD_W-1:0] spr_y,
  input  logic [NUM_SPR*BPP-1:0]     spr_code,
  output logic                       spr_row_req,
  output logic [SEL_W-1:0]           spr_row_idx,
  output logic [ROW_W-1:0]           spr_row_addr,
  input  logic [SPR_W-1:0]           spr_row_data,
  input  logic                       pal_we,
  input  logic [BPP-1:0]             pal_addr,
  input  logic [23:0]                pal_data,
  input  logic                       pixel_en,
  output logic [7:0]                 red,
  output logic [7:0]                 green,
  output logic [7:0]                 blue,
  output logic                       line_ready,
  output logic                       overrun
);

  localparam int unsigned ADDR_W = $clog2(H_ACTIVE);
  localparam int unsigned PIX_W  = $clog2(H_ACTIVE + 1);
  localparam int unsigned CNT_W  = $clog2(NUM_SPR + 1);
  localparam int unsigned PAL_N  = 2 ** BPP;

  typedef enum logic [1:0] {IDLE, SCAN, MERGE, DONE} state_t;

  function automatic logic [PAL_N-1:0][23:0] pal_default();
    logic [PAL_N-1:0][23:0] p;
    p = '0;
    for (int unsigned e = 0; e < PAL_N; e++) begin
      case (e)
        1: p[e] = 24'hFF0000;
        2: p[e] = 24'h00FF00;
        3: p[e] = 24'h0000FF;
        default: p[e] = '0;
      endcase
    end
    return p;
  endfunction

  state_t                        state, state_nxt;
  logic [CNT_W-1:0]              idx, idx_nxt;
  logic [SEL_W-1:0]              sel;
  logic                          buf_sel;
  logic [H_ACTIVE-1:0][BPP-1:0]  lbuf [2];
  logic [PAL_N-1:0][23:0]        pal;
  logic [PIX_W-1:0]              pcnt;
  logic [23:0]                   rgb;
  logic [BPP-1:0]                disp_code;

  logic [COORD_W-1:0]            x_arr [NUM_SPR];
  logic [COORD_W-1:0]            y_arr [NUM_SPR];
  logic [BPP-1:0]                c_arr [NUM_SPR];
  logic [COORD_W-1:0]            cur_x, cur_y;
  logic [BPP-1:0]                cur_code;
  logic                          spr_hit;
  logic [COORD_W:0]              merge_col [SPR_W];
  logic [SPR_W-1:0]              merge_wr;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SPR; i++) begin
      x_arr[i] = spr_x[i*COORD_W +: COORD_W];
      y_arr[i] = spr_y[i*COORD_W +: COORD_W];
      c_arr[i] = spr_code[i*BPP +: BPP];
    end
  end

  assign sel      = idx[SEL_W-1:0];
  assign cur_x    = x_arr[sel];
  assign cur_y    = y_arr[sel];
  assign cur_code = c_arr[sel];
  // One extra bit so spr_y + SPR_H near the top of the coordinate range cannot wrap.
  assign spr_hit  = spr_en[sel] && ({1'b0, line_y} >= {1'b0, cur_y}) &&
                    ({1'b0, line_y} < ({1'b0, cur_y} + (COORD_W+1)'(SPR_H)));

  always_comb begin
    for (int unsigned k = 0; k < SPR_W; k++) begin
      merge_col[k] = {1'b0, cur_x} + (COORD_W+1)'(k);
      merge_wr[k]  = spr_row_data[k] && (merge_col[k] < (COORD_W+1)'(H_ACTIVE));
    end
  end

  always_ff @(posedge pixelCLK) begin
    if (RST) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    spr_row_req  = 1'b0;
    spr_row_idx  = '0;
    spr_row_addr = '0;
    line_ready   = 1'b0;
    case (state)
      SCAN: begin
        if (idx == CNT_W'(NUM_SPR)) begin
          state_nxt  = DONE;
          line_ready = 1'b1;
        end else if (spr_hit) begin
          spr_row_req  = 1'b1;
          spr_row_idx  = sel;
          spr_row_addr = ROW_W'(line_y - cur_y);
          state_nxt    = MERGE;
        end else begin
          idx_nxt = idx + CNT_W'(1);
        end
      end
      MERGE: begin
        idx_nxt   = idx + CNT_W'(1);
        state_nxt = SCAN;
      end
      default: ;
    endcase
    if (line_start) begin
      state_nxt = SCAN;
      idx_nxt   = '0;
    end
  end

  // buf_sel names the display buffer; the compose buffer is always the other one.
  always_ff @(posedge pixelCLK) begin
    if (RST) begin
      lbuf[0] <= '0;
      lbuf[1] <= '0;
    end else if (line_start) begin
      lbuf[buf_sel] <= map_line;
    end else if (state == MERGE) begin
      for (int unsigned k = 0; k < SPR_W; k++) begin
        if (merge_wr[k]) lbuf[~buf_sel][merge_col[k][ADDR_W-1:0]] <= cur_code;
      end
    end
  end

  always_ff @(posedge pixelCLK) begin
    if (RST) begin
      buf_sel <= 1'b0;
      overrun <= 1'b0;
      pcnt    <= '0;
    end else if (line_start) begin
      buf_sel <= ~buf_sel;
      pcnt    <= '0;
      if (state == SCAN || state == MERGE) overrun <= 1'b1;
    end else if (pixel_en && pcnt < PIX_W'(H_ACTIVE)) begin
      pcnt <= pcnt + PIX_W'(1);
    end
  end

  assign disp_code = lbuf[buf_sel][pcnt[ADDR_W-1:0]];

  always_ff @(posedge pixelCLK) begin
    if (RST) begin
      pal <= pal_default();
      rgb <= '0;
    end else begin
      if (pal_we) pal[pal_addr] <= pal_data;
      if (pixel_en && pcnt < PIX_W'(H_ACTIVE)) rgb <= pal[disp_code];
      else rgb <= '0;
    end
  end

  assign {red, green, blue} = rgb;

endmodule

// File: tb/tb_vga_sprite_line_compositor.sv
// Scoreboard bench: stimulus queues expected pixels, row fetches and line_ready
// latencies; independent monitors pop and compare as the DUT produces them.
module tb_vga_sprite_line_compositor;

  localparam int H = 848;

  logic          clk = 1'b0;
  logic          RST, line_start, pal_we, pixel_en;
  logic [10:0]   line_y;
  logic [1695:0] map_line;
  logic [1:0]    spr_en;
  logic [21:0]   spr_x, spr_y;
  logic [3:0]    spr_code;
  logic          spr_row_req;
  logic [0:0]    spr_row_idx;
  logic [5:0]    spr_row_addr;
  logic [56:0]   spr_row_data;
  logic [1:0]    pal_addr;
  logic [23:0]   pal_data;
  logic [7:0]    red, green, blue;
  logic          line_ready, overrun;

  int tests = 0;
  int fails = 0;
  int pix_q[$];
  int req_q[$];
  int rdy_q[$];

  vga_sprite_line_compositor #(
    .H_ACTIVE(848), .BPP(2), .NUM_SPR(2), .SPR_W(57), .SPR_H(57), .COORD_W(11)
  ) dut (
    .pixelCLK(clk), .RST(RST), .line_start(line_start), .line_y(line_y),
    .map_line(map_line), .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y),
    .spr_code(spr_code), .spr_row_req(spr_row_req), .spr_row_idx(spr_row_idx),
    .spr_row_addr(spr_row_addr), .spr_row_data(spr_row_data), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_data(pal_data), .pixel_en(pixel_en),
    .red(red), .green(green), .blue(blue), .line_ready(line_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected colour of pixel p for each displayed line, from the directed cases.
  function automatic int exp_pix(input int line_id, input int p);
    if (p >= H) return 0;
    case (line_id)
      1: return 0;
      2: return 32'h00FF00;
      3: return (p >= 100 && p <= 156) ? 32'hFF0000 : 32'h00FF00;
      4: return (p >= 200 && p <= 229) ? 32'hFF0000 :
                (p >= 230 && p <= 286) ? 32'h0000FF : 32'h00FF00;
      5: return (p >= 820) ? 32'h0000FF : 32'h00FF00;
      6: return (p >= 100 && p <= 120) ? 32'hFF0000 :
                (p >= 121 && p <= 156) ? 32'h123456 : 32'h00FF00;
      7: return 32'hFF0000;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // Pixel monitor: a sampled pixel_en means RGB is valid at the following negedge.
  initial begin
    logic v, r;
    int e;
    forever begin
      @(posedge clk); v = pixel_en; r = RST;
      @(negedge clk);
      if (v && !r) begin
        e = (pix_q.size() > 0) ? pix_q.pop_front() : 32'hDEADBEEF;
        chk("pixel_rgb", {8'h00, red, green, blue}, e);
      end else begin
        chk("blank_rgb", {8'h00, red, green, blue}, 32'h0);
      end
    end
  end

  // line_ready monitor: cycles counted from the line_start edge.
  initial begin
    logic ls, r, active;
    int n, e;
    active = 1'b0; n = 0;
    forever begin
      @(posedge clk); ls = line_start; r = RST;
      @(negedge clk);
      if (r) active = 1'b0;
      else if (ls) begin n = 0; active = 1'b1; end
      else if (active) n++;
      if (!r && line_ready) begin
        e = (rdy_q.size() > 0) ? rdy_q.pop_front() : -1;
        chk("line_ready_latency", n, e);
        active = 1'b0;
      end
    end
  end

  // Sprite store model: checks each fetch and returns an all-ones row one cycle later.
  initial begin
    logic r;
    int e;
    spr_row_data = '0;
    forever begin
      @(negedge clk);
      r = (RST === 1'b0) && (spr_row_req === 1'b1);
      if (r) begin
        e = (req_q.size() > 0) ? req_q.pop_front() : 32'hFFFF;
        chk("row_fetch", {spr_row_idx, spr_row_addr}, e);
      end
      @(posedge clk);
      #1 spr_row_data = r ? '1 : '0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog no completion by t=%0t", $time);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic set_map(input logic [1:0] code);
    for (int p = 0; p < H; p++) map_line[p*2 +: 2] = code;
  endtask

  task automatic set_spr(input logic [1:0] en, input int ly,
                         input int x0, input int y0, input logic [1:0] c0,
                         input int x1, input int y1, input logic [1:0] c1);
    spr_en   = en;
    line_y   = 11'(ly);
    spr_x    = {11'(x1), 11'(x0)};
    spr_y    = {11'(y1), 11'(y0)};
    spr_code = {c1, c0};
  endtask

  task automatic req(input int i, input int a);
    req_q.push_back(i * 64 + a);
  endtask

  task automatic pulse_ls(input int lat);
    if (lat >= 0) rdy_q.push_back(lat);
    line_start = 1'b1;
    tick(1);
    line_start = 1'b0;
  endtask

  task automatic stream(input int line_id, input int n, input int pal_at);
    for (int p = 0; p < n; p++) begin
      pixel_en = 1'b1;
      pal_we   = (p == pal_at);
      pix_q.push_back(exp_pix(line_id, p));
      tick(1);
    end
    pixel_en = 1'b0;
    pal_we   = 1'b0;
  endtask

  initial begin
    RST = 1'b1; line_start = 1'b0; pal_we = 1'b0; pixel_en = 1'b0;
    pal_addr = 2'd1; pal_data = 24'h123456;
    set_map(2'd2);
    set_spr(2'b00, 0, 0, 0, 2'd0, 0, 0, 2'd0);
    tick(3);
    RST = 1'b0;
    chk("reset_rgb", {8'h00, red, green, blue}, 32'h0);
    chk("reset_line_ready", line_ready, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_row_req", {spr_row_req, spr_row_idx, spr_row_addr}, 0);

    // Map only; displayed buffer is still the cleared one.
    pulse_ls(2);
    stream(1, 4, -1);
    tick(6);

    // Sprite0 at x=100 on its first row; sprite1 would hit but is disabled.
    set_spr(2'b01, 50, 100, 50, 2'd1, 0, 50, 2'd3);
    req(0, 0);
    pulse_ls(3);
    stream(2, H + 2, -1);

    // Overlapping sprites, sprite1 drawn last.
    set_spr(2'b11, 60, 200, 40, 2'd1, 230, 45, 2'd3);
    req(0, 20); req(1, 15);
    pulse_ls(4);
    stream(3, H, -1);

    // Right-edge clip; sprite1 is one row past its bottom, so no fetch.
    set_spr(2'b11, 100, 820, 90, 2'd3, 0, 43, 2'd1);
    req(0, 10);
    pulse_ls(3);
    stream(4, H, -1);

    set_spr(2'b01, 50, 100, 50, 2'd1, 0, 0, 2'd0);
    req(0, 0);
    pulse_ls(3);
    stream(5, H, -1);

    // Palette entry 1 rewritten while pixel 120 is being read.
    set_spr(2'b00, 0, 0, 0, 2'd0, 0, 0, 2'd0);
    pulse_ls(2);
    stream(6, H, 120);
    tick(4);
    chk("overrun_clear", overrun, 0);

    // Second line_start lands while the first compose is mid-merge.
    set_spr(2'b11, 5, 0, 0, 2'd1, 10, 0, 2'd3);
    req(0, 5); req(0, 5); req(1, 5);
    pulse_ls(-1);
    tick(1);
    pulse_ls(4);
    tick(10);
    chk("overrun_set", overrun, 1);
    tick(5);
    chk("overrun_sticky", overrun, 1);

    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    chk("rst_rgb", {8'h00, red, green, blue}, 32'h0);
    chk("rst_overrun", overrun, 0);
    chk("rst_line_ready", line_ready, 0);
    chk("rst_row_req", spr_row_req, 0);

    // Code-1 map line must show the default red again.
    set_map(2'd1);
    set_spr(2'b00, 0, 0, 0, 2'd0, 0, 0, 2'd0);
    pulse_ls(2);
    tick(8);
    pulse_ls(2);
    stream(7, 4, -1);
    tick(8);

    chk("pix_q_drained", pix_q.size(), 0);
    chk("req_q_drained", req_q.size(), 0);
    chk("rdy_q_drained", rdy_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
